aes_sched: RTL and testbench

AES_SCHED -- requirements
Module: aes_sched

---
 rtl/aes_sched_pkg.sv | 15 +
 rtl/aes_sched_rr_arbiter.sv | 67 ++++++
 rtl/aes_sched.sv | 112 +++++++++++
 tb/tb_aes_sched.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES-128 request scheduler.
package aes_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ROUND,
        HOLD
    } state_t;

    localparam int AES_ROUNDS = 10;
    localparam int COUNT_W    = 4;
    localparam int BLK_W      = 128;

endpackage

// File: rtl/aes_sched_rr_arbiter.sv
// Requester arbiter: round-robin when AES_SCHED_RR_EN is defined,
// otherwise fixed priority (lowest index wins) with no pointer state.
module aes_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               accept,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

`ifdef AES_SCHED_RR_EN
    // ptr holds the index where the next search starts (one past the last winner)
    logic [ID_W-1:0] ptr;
    logic            found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && i >= 32'(ptr)) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                idx      = ID_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                idx      = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept && found) begin
            ptr <= (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + ID_W'(1);
        end
    end
`else
    logic unused_ok;
    logic found;

    assign unused_ok = ^{clk, rst_n, accept};

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                idx      = ID_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/aes_sched.sv
// Shares one iterative AES-128 engine among NUM_REQ requesters.
// Arbitration is round-robin when AES_SCHED_RR_EN is defined, fixed priority otherwise.
module aes_sched
    import aes_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*BLK_W-1:0] req_plane,
    input  logic [NUM_REQ*BLK_W-1:0] req_key,
    output logic [BLK_W-1:0]         eng_plane,
    output logic [BLK_W-1:0]         eng_key,
    output logic                     eng_sel,
    output logic                     eng_reg_en,
    output logic [COUNT_W-1:0]       eng_count,
    input  logic [BLK_W-1:0]         eng_cipher,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BLK_W-1:0]         out_cipher,
    output logic [ID_W-1:0]          out_id
);

    state_t               state;
    logic                 accept;
    logic [NUM_REQ-1:0]   grant;
    logic [ID_W-1:0]      win_idx;
    logic [BLK_W-1:0]     op_plane;
    logic [BLK_W-1:0]     op_key;
    logic [BLK_W-1:0]     plane_arr [NUM_REQ];
    logic [BLK_W-1:0]     key_arr   [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
        assign plane_arr[g] = req_plane[g*BLK_W +: BLK_W];
        assign key_arr[g]   = req_key[g*BLK_W +: BLK_W];
    end

    // rst_n gates accept so no strobe escapes while reset is asserted
    assign accept = rst_n && (state == IDLE || (state == HOLD && out_ready)) && (|req_valid);

    aes_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_valid),
        .accept (accept),
        .grant  (grant),
        .idx    (win_idx)
    );

    assign req_ready  = accept ? grant : '0;
    assign eng_plane  = op_plane;
    assign eng_key    = op_key;
    assign out_cipher = out_valid ? eng_cipher : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            eng_sel    <= 1'b0;
            eng_reg_en <= 1'b0;
            eng_count  <= '0;
            out_valid  <= 1'b0;
            op_plane   <= '0;
            op_key     <= '0;
            out_id     <= '0;
        end else if (accept) begin
            op_plane   <= plane_arr[win_idx];
            op_key     <= key_arr[win_idx];
            out_id     <= win_idx;
            state      <= LOAD;
            eng_sel    <= 1'b0;
            eng_reg_en <= 1'b1;
            eng_count  <= '0;
            out_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: ;
                LOAD: begin
                    state     <= ROUND;
                    eng_sel   <= 1'b1;
                    eng_count <= COUNT_W'(1);
                end
                ROUND: begin
                    if (eng_count == COUNT_W'(AES_ROUNDS - 1)) begin
                        state      <= HOLD;
                        eng_reg_en <= 1'b0;
                        eng_count  <= COUNT_W'(AES_ROUNDS);
                        out_valid  <= 1'b1;
                    end else begin
                        eng_count <= eng_count + COUNT_W'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state      <= IDLE;
                        eng_sel    <= 1'b0;
                        eng_reg_en <= 1'b0;
                        eng_count  <= '0;
                        out_valid  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_sched.sv
// Directed bench for aes_sched with a behavioural round-iterative AES-128 engine.
module tb_aes_sched;

    logic           clk;
    logic           rst_n;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [255:0]   req_plane;
    logic [255:0]   req_key;
    logic [127:0]   eng_plane;
    logic [127:0]   eng_key;
    logic           eng_sel;
    logic           eng_reg_en;
    logic [3:0]     eng_count;
    logic [127:0]   eng_cipher;
    logic           out_valid;
    logic           out_ready;
    logic [127:0]   out_cipher;
    logic [0:0]     out_id;

    int checks   = 0;
    int failures = 0;

    aes_sched #(
        .NUM_REQ (2),
        .ID_W    (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_plane  (req_plane),
        .req_key    (req_key),
        .eng_plane  (eng_plane),
        .eng_key    (eng_key),
        .eng_sel    (eng_sel),
        .eng_reg_en (eng_reg_en),
        .eng_count  (eng_count),
        .eng_cipher (eng_cipher),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_cipher (out_cipher),
        .out_id     (out_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box from first principles: GF(2^8) inverse (x^254) then affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0]  r;
        logic [15:0] t;
        logic [7:0]  e;
        e = 8'hfe;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gm(r, r);
            if (e[i]) r = gm(r, x);
        end
        t = {r, r};
        return r ^ t[14:7] ^ t[13:6] ^ t[12:5] ^ t[11:4] ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input int c);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 1; i < c; i++) r = xt(r);
        return r;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        w3 = k[31:0];
        t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [7:0]   a  [16];
        logic [7:0]   sr [16];
        logic [7:0]   mc [16];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) sr[r+4*c] = a[r+4*((c+r)%4)];
        for (int c = 0; c < 4; c++) begin
            mc[4*c]   = gm(sr[4*c], 8'h02) ^ gm(sr[4*c+1], 8'h03) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c] ^ gm(sr[4*c+1], 8'h02) ^ gm(sr[4*c+2], 8'h03) ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ gm(sr[4*c+2], 8'h02) ^ gm(sr[4*c+3], 8'h03);
            mc[4*c+3] = gm(sr[4*c], 8'h03) ^ sr[4*c+1] ^ sr[4*c+2] ^ gm(sr[4*c+3], 8'h02);
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = last ? sr[i] : mc[i];
        return res ^ rk;
    endfunction

    // Engine model driven purely by the scheduler's control outputs
    logic [127:0] e_st;
    logic [127:0] e_rk;

    always @(posedge clk) begin
        if (eng_reg_en) begin
            if (!eng_sel) begin
                e_st <= eng_plane ^ eng_key;
                e_rk <= eng_key;
            end else begin
                e_st <= aes_round(e_st, next_key(e_rk, rcon(int'(eng_count))), 1'b0);
                e_rk <= next_key(e_rk, rcon(int'(eng_count)));
            end
        end
    end

    assign eng_cipher = aes_round(e_st, next_key(e_rk, rcon(10)), 1'b1);

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [127:0] vp [2];
    logic [127:0] vk [2];
    logic [127:0] vc [2];
    int           exp_id;

    initial begin
        vp[0] = 128'h00112233445566778899aabbccddeeff;
        vk[0] = 128'h000102030405060708090a0b0c0d0e0f;
        vc[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        vp[1] = 128'h3243f6a8885a308d313198a2e0370734;
        vk[1] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        vc[1] = 128'h3925841d02dc09fbdc118597196a0b32;

        rst_n     = 1'b0;
        out_ready = 1'b1;
        req_valid = 2'b01;
        req_plane = {vp[1], vp[0]};
        req_key   = {vk[1], vk[0]};
        tick();
        tick();
        chk("rst_req_ready", 128'(req_ready), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_cipher", out_cipher, 128'(0));
        chk("rst_out_id", 128'(out_id), 128'(0));
        chk("rst_eng_sel", 128'(eng_sel), 128'(0));
        chk("rst_eng_reg_en", 128'(eng_reg_en), 128'(0));
        chk("rst_eng_count", 128'(eng_count), 128'(0));
        chk("rst_eng_plane", eng_plane, 128'(0));

        // single request from requester 0, latency and FIPS-197 result
        rst_n = 1'b1;
        #1;
        chk("idle_accept_ready", 128'(req_ready), 128'(2'b01));
        tick();
        chk("load_sel", 128'(eng_sel), 128'(0));
        chk("load_reg_en", 128'(eng_reg_en), 128'(1));
        chk("load_count", 128'(eng_count), 128'(0));
        chk("load_plane", eng_plane, vp[0]);
        chk("load_key", eng_key, vk[0]);
        req_plane = ~req_plane;
        req_key   = ~req_key;
        req_valid = 2'b00;
        tick();
        chk("round1_sel", 128'(eng_sel), 128'(1));
        chk("round1_count", 128'(eng_count), 128'(1));
        repeat (8) tick();
        chk("round9_count", 128'(eng_count), 128'(9));
        chk("round9_out_valid", 128'(out_valid), 128'(0));
        out_ready = 1'b0;
        tick();
        chk("hold_out_valid", 128'(out_valid), 128'(1));
        chk("hold_count", 128'(eng_count), 128'(10));
        chk("hold_reg_en", 128'(eng_reg_en), 128'(0));
        chk("hold_cipher", out_cipher, vc[0]);
        chk("hold_id", 128'(out_id), 128'(0));

        // stall in HOLD with requests pending
        req_plane = {vp[1], vp[0]};
        req_key   = {vk[1], vk[0]};
        req_valid = 2'b11;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("stall_req_ready", 128'(req_ready), 128'(0));
            chk("stall_out_valid", 128'(out_valid), 128'(1));
            chk("stall_cipher", out_cipher, vc[0]);
            chk("stall_count", 128'(eng_count), 128'(10));
            chk("stall_reg_en", 128'(eng_reg_en), 128'(0));
            tick();
        end

        // HOLD with no request returns to IDLE
        req_valid = 2'b00;
        out_ready = 1'b1;
        #1;
        chk("hold_release_ready", 128'(req_ready), 128'(0));
        tick();
        chk("idle_out_valid", 128'(out_valid), 128'(0));
        chk("idle_count", 128'(eng_count), 128'(0));
        chk("idle_sel", 128'(eng_sel), 128'(0));
        chk("idle_reg_en", 128'(eng_reg_en), 128'(0));

        // fresh reset, then four back-to-back blocks with both requesters active
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        req_valid = 2'b11;
        for (int b = 0; b < 4; b++) begin
`ifdef AES_SCHED_RR_EN
            exp_id = b % 2;
`else
            exp_id = 0;
`endif
            #1;
            chk("stream_grant", 128'(req_ready), 128'(2'b01 << exp_id));
            tick();
            chk("stream_load_sel", 128'(eng_sel), 128'(0));
            chk("stream_load_reg_en", 128'(eng_reg_en), 128'(1));
            chk("stream_load_plane", eng_plane, vp[exp_id]);
            repeat (10) tick();
            chk("stream_out_valid", 128'(out_valid), 128'(1));
            chk("stream_out_id", 128'(out_id), 128'(exp_id));
            chk("stream_cipher", out_cipher, vc[exp_id]);
        end

        // requester 1 accepted from HOLD, then reset asserted at round 5
        req_valid = 2'b10;
        #1;
        chk("r1_grant", 128'(req_ready), 128'(2'b10));
        tick();
        req_valid = 2'b00;
        repeat (5) tick();
        chk("mid_count", 128'(eng_count), 128'(5));
        rst_n = 1'b0;
        #1;
        chk("async_count", 128'(eng_count), 128'(0));
        chk("async_sel", 128'(eng_sel), 128'(0));
        chk("async_reg_en", 128'(eng_reg_en), 128'(0));
        chk("async_out_valid", 128'(out_valid), 128'(0));
        chk("async_out_id", 128'(out_id), 128'(0));
        chk("async_plane", eng_plane, 128'(0));
        chk("async_key", eng_key, 128'(0));
        tick();
        tick();
        chk("rst_hold_out_valid", 128'(out_valid), 128'(0));

        // data present without valid must not be captured
        req_plane = ~req_plane;
        rst_n     = 1'b1;
        tick();
        tick();
        chk("nocapture_plane", eng_plane, 128'(0));
        chk("nocapture_out_valid", 128'(out_valid), 128'(0));

        req_plane = {vp[1], vp[0]};
        req_valid = 2'b10;
        #1;
        chk("post_rst_grant", 128'(req_ready), 128'(2'b10));
        tick();
        req_valid = 2'b00;
        repeat (10) tick();
        chk("post_rst_out_valid", 128'(out_valid), 128'(1));
        chk("post_rst_out_id", 128'(out_id), 128'(1));
        chk("post_rst_cipher", out_cipher, vc[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
